mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MIPS memory stage. Owns the EX/MEM, MEM/WB and WB/after pipeline registers and the word-addressed data memory.
- Publishes the three destination-register fields (exmem_rd, memwb_rd, after_rd) to the store-data forwarding unit.
- Consumes that unit's 2-bit select (memout) to pick the data written by SW.
- Sits between EX and the register-file writeback.

Parameters:
- DEPTH, 256, number of 32-bit data memory words.
- ADDR_W, 8, word-index width, log2(DEPTH).
- OP_LW, 6'h23, load-word opcode.
- OP_SW, 6'h2B, store-word opcode.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold EX/MEM and inject a bubble into MEM/WB.
- flush  in  1  replace the incoming EX/MEM capture with a bubble.
- ex_op  in  6  opcode leaving EX.
- ex_alu_result  in  32  ALU result / effective address.
- ex_store_data  in  32  rt value for SW.
- ex_rd  in  5  destination register (rt for SW).
- ex_regwrite  in  1  instruction writes the register file.
- memout  in  2  store-data forward select: 0 none, 1 MEM/WB, 2 after.
- exmem_op  out  6  EX/MEM opcode.
- exmem_rd  out  5  EX/MEM rd.
- memwb_rd  out  5  MEM/WB rd.
- after_rd  out  5  WB/after rd.
- memwb_result  out  32  load data or ALU result in MEM/WB.
- memwb_regwrite  out  1  MEM/WB write enable.
- after_result  out  32  WB/after result.
- after_regwrite  out  1  WB/after write enable.
- align_err  out  1  sticky misaligned LW/SW flag.

Behaviour:
- Reset (synchronous, checked on the clock edge):
  - All pipeline register fields go to 0, so every output is 0.
  - align_err clears to 0.
  - Data memory contents are not cleared.
- EX/MEM register: fields are op, alu_result, store_data, rd, regwrite. Each edge:
  - flush=1: load the bubble (all zero). flush wins over stall.
  - else stall=1: hold.
  - else: capture the ex_* inputs.
- Word index is exmem alu_result[ADDR_W+1:2]. Upper bits are ignored, so addresses alias modulo DEPTH.
- Misaligned means exmem alu_result[1:0] != 0.
- Store data select (combinational):
  - memout=1: memwb_result.
  - memout=2: after_result.
  - memout=0 or 3: EX/MEM store_data.
- Store: mem[index] is written at the edge when all of the following hold:
  - exmem_op==OP_SW
  - aligned
  - stall=0
  - reset=0
  Write latency is 1 edge.
- Load:
  - Asynchronous read of mem[index].
  - Captured into memwb_result at the edge, so it is visible one cycle after the LW is in EX/MEM.
  - A misaligned LW captures 32'h0.
- MEM/WB register. Each edge:
  - stall=1: bubble (rd=0, regwrite=0, result=0).
  - else: rd and regwrite from EX/MEM; result is load data for LW, otherwise alu_result.
  - SW and any op with regwrite=0 pass their rd unchanged.
- WB/after register:
  - Captures MEM/WB rd, result and regwrite every edge unconditionally. It is not affected by stall or flush.
  - after_* outputs come from this register.
- align_err is set at the edge where exmem_op is OP_LW or OP_SW, the access is misaligned and stall=0. It holds until reset.
- A load immediately following a store to the same word returns the stored value, because the write completes at the edge before the load's read.
- Forwarding to SW uses the current register contents of MEM/WB and after, not the writeback path.

Test Plan:
- Reset with outputs driven nonzero -> all outputs 0 on the next edge; a prior mem[4] value is retained and readable by LW 0x10.
- SW addr 0x10, data 0xDEADBEEF, memout=0, then LW rd=5 addr 0x10 -> memwb_result=0xDEADBEEF, memwb_rd=5, memwb_regwrite=1 one cycle after the LW enters EX/MEM.
- Store forwarding:
  - Step: ADD producing 0x1234 to rd=8 is in MEM/WB while SW rt=8 addr 0x20 stale 0x0 is in EX/MEM with memout=1. Required response: mem[8]=0x1234.
  - Step: repeat with memout=2 and after_result=0x55AA. Required response: mem[8]=0x55AA.
- stall=1 for 2 cycles with SW in EX/MEM -> exmem_* held, memwb_regwrite=0 both cycles, exactly one write once stall drops.
- stall=1 and flush=1 together -> EX/MEM becomes a bubble (exmem_op=0, exmem_rd=0), no store occurs.
- SW addr 0x13 -> no memory write, align_err=1 and stays 1; LW addr 0x02 -> memwb_result=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: the MIPS memory stage.
//
// Holds the EX/MEM, MEM/WB and WB/after pipeline registers and a word-addressed
// data memory. LW reads the memory asynchronously and captures the word into
// MEM/WB. SW writes at the clock edge, one edge after it reaches EX/MEM. The
// data that SW writes can be forwarded from MEM/WB or WB/after.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   stall                 hold EX/MEM, push a bubble into MEM/WB
//   flush                 replace the incoming EX/MEM capture with a bubble
//   ex_*                  instruction leaving EX (op, address, rt data, rd, regwrite)
//   memout                store-data select: 0/3 EX/MEM, 1 MEM/WB, 2 WB/after
//   exmem_op, exmem_rd    EX/MEM fields, visible to the forwarding unit
//   memwb_*               MEM/WB rd, result and write enable
//   after_*               WB/after rd, result and write enable
//   align_err             sticky flag for a misaligned LW/SW
module mem_access_stage #(
    parameter int         DEPTH  = 256,
    parameter int         ADDR_W = 8,
    parameter logic [5:0] OP_LW  = 6'h23,
    parameter logic [5:0] OP_SW  = 6'h2B
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [5:0]  ex_op,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwrite,
    input  logic [1:0]  memout,
    output logic [5:0]  exmem_op,
    output logic [4:0]  exmem_rd,
    output logic [4:0]  memwb_rd,
    output logic [4:0]  after_rd,
    output logic [31:0] memwb_result,
    output logic        memwb_regwrite,
    output logic [31:0] after_result,
    output logic        after_regwrite,
    output logic        align_err
);

    logic [31:0] exmem_alu_result;
    logic [31:0] exmem_store_data;
    logic        exmem_regwrite;

    logic [31:0] mem [DEPTH];

    logic [ADDR_W-1:0] index;
    logic              misaligned;
    logic [31:0]       store_data;
    logic [31:0]       load_data;
    logic              store_en;

    // EX/MEM register. A flush takes priority over a stall, so that a squashed
    // instruction cannot stay parked in the stage.
    // NOTE: state registers use non-blocking (<=) assignments. Every register
    // then samples the values from before the edge, whatever the process order.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            exmem_op         <= '0;
            exmem_alu_result <= '0;
            exmem_store_data <= '0;
            exmem_rd         <= '0;
            exmem_regwrite   <= 1'b0;
        end else if (!stall) begin
            exmem_op         <= ex_op;
            exmem_alu_result <= ex_alu_result;
            exmem_store_data <= ex_store_data;
            exmem_rd         <= ex_rd;
            exmem_regwrite   <= ex_regwrite;
        end
    end

    // Address bits above the word index are dropped, so addresses alias modulo DEPTH.
    assign index      = exmem_alu_result[ADDR_W+1:2];
    assign misaligned = (exmem_alu_result[1:0] != 2'b00);

    // The forwarding sources are the registered MEM/WB and WB/after values,
    // not the writeback path.
    // NOTE: each signal written in always_comb gets a default first. Without
    // it, an uncovered path infers a latch.
    always_comb begin
        store_data = exmem_store_data;
        case (memout)
            2'd1:    store_data = memwb_result;
            2'd2:    store_data = after_result;
            default: store_data = exmem_store_data;
        endcase
    end

    assign store_en  = !reset && !stall && (exmem_op == OP_SW) && !misaligned;
    assign load_data = misaligned ? 32'h0 : mem[index];

    // NOTE: the data memory has no reset. Its contents survive a pipeline
    // reset, and it maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (store_en) begin
            mem[index] <= store_data;
        end
    end

    // MEM/WB register. A stall leaves EX/MEM in place and sends a bubble
    // downstream.
    always_ff @(posedge clock) begin
        if (reset || stall) begin
            memwb_rd       <= '0;
            memwb_result   <= '0;
            memwb_regwrite <= 1'b0;
        end else begin
            memwb_rd       <= exmem_rd;
            memwb_regwrite <= exmem_regwrite;
            memwb_result   <= (exmem_op == OP_LW) ? load_data : exmem_alu_result;
        end
    end

    // WB/after register. It always advances, so forwarding can still reach the
    // last retired result while the front of the pipe is stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            after_rd       <= '0;
            after_result   <= '0;
            after_regwrite <= 1'b0;
        end else begin
            after_rd       <= memwb_rd;
            after_result   <= memwb_result;
            after_regwrite <= memwb_regwrite;
        end
    end

    // A stalled access is not counted yet; it is reported when it proceeds.
    always_ff @(posedge clock) begin
        if (reset) begin
            align_err <= 1'b0;
        end else if (!stall && misaligned && (exmem_op == OP_LW || exmem_op == OP_SW)) begin
            align_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage.
//
// A behavioural model predicts every output from the stage rules on each cycle.
// A compare process checks the DUT against it on every falling edge. Directed
// sequences with literal expectations pin the model. They are followed by
// randomized traffic over a few aliased words.
module tb_mem_access_stage;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_ADD = 6'h00;

    logic        clock = 1'b0;
    logic        reset, stall, flush;
    logic [5:0]  ex_op;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic [1:0]  memout;
    logic [5:0]  exmem_op;
    logic [4:0]  exmem_rd, memwb_rd, after_rd;
    logic [31:0] memwb_result, after_result;
    logic        memwb_regwrite, after_regwrite, align_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_stage dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .ex_op          (ex_op),
        .ex_alu_result  (ex_alu_result),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_regwrite    (ex_regwrite),
        .memout         (memout),
        .exmem_op       (exmem_op),
        .exmem_rd       (exmem_rd),
        .memwb_rd       (memwb_rd),
        .after_rd       (after_rd),
        .memwb_result   (memwb_result),
        .memwb_regwrite (memwb_regwrite),
        .after_result   (after_result),
        .after_regwrite (after_regwrite),
        .align_err      (align_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [5:0]  op;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw;
    } ex_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
        logic        rw;
        bit          known;   // result value is defined (not from uninitialised RAM)
    } wb_t;

    ex_t         m_ex;
    wb_t         m_wb, m_af, n_wb;
    logic [31:0] m_mem   [256];
    bit          m_known [256];
    bit          m_err   = 1'b0;
    bit          m_valid = 1'b0;
    int          m_idx;
    bit          m_mis;
    logic [31:0] m_sd;
    bit          m_sdk;

    initial begin
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    end

    always @(posedge clock) begin
        if (reset) begin
            m_ex    = '{op: 6'h0, alu: 32'h0, sd: 32'h0, rd: 5'h0, rw: 1'b0};
            m_wb    = '{rd: 5'h0, res: 32'h0, rw: 1'b0, known: 1'b1};
            m_af    = m_wb;
            m_err   = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_idx = int'(m_ex.alu[9:2]);
            m_mis = (m_ex.alu % 4) != 0;
            if (memout == 2'd1) begin
                m_sd = m_wb.res; m_sdk = m_wb.known;
            end else if (memout == 2'd2) begin
                m_sd = m_af.res; m_sdk = m_af.known;
            end else begin
                m_sd = m_ex.sd;  m_sdk = 1'b1;
            end
            if (stall) begin
                n_wb = '{rd: 5'h0, res: 32'h0, rw: 1'b0, known: 1'b1};
            end else if (m_ex.op == OP_LW) begin
                n_wb = '{rd: m_ex.rd, res: m_mis ? 32'h0 : m_mem[m_idx], rw: m_ex.rw,
                         known: m_mis ? 1'b1 : m_known[m_idx]};
            end else begin
                n_wb = '{rd: m_ex.rd, res: m_ex.alu, rw: m_ex.rw, known: 1'b1};
            end
            if (!stall && m_ex.op == OP_SW && !m_mis) begin
                m_mem[m_idx]   = m_sd;
                m_known[m_idx] = m_sdk;
            end
            if (!stall && m_mis && (m_ex.op == OP_LW || m_ex.op == OP_SW)) m_err = 1'b1;
            m_af = m_wb;
            m_wb = n_wb;
            if (flush)
                m_ex = '{op: 6'h0, alu: 32'h0, sd: 32'h0, rd: 5'h0, rw: 1'b0};
            else if (!stall)
                m_ex = '{op: ex_op, alu: ex_alu_result, sd: ex_store_data, rd: ex_rd, rw: ex_regwrite};
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("exmem_op",       32'(exmem_op),       32'(m_ex.op));
            check("exmem_rd",       32'(exmem_rd),       32'(m_ex.rd));
            check("memwb_rd",       32'(memwb_rd),       32'(m_wb.rd));
            check("memwb_regwrite", 32'(memwb_regwrite), 32'(m_wb.rw));
            check("after_rd",       32'(after_rd),       32'(m_af.rd));
            check("after_regwrite", 32'(after_regwrite), 32'(m_af.rw));
            check("align_err",      32'(align_err),      32'(m_err));
            if (m_wb.known) check("memwb_result", memwb_result, m_wb.res);
            if (m_af.known) check("after_result", after_result, m_af.res);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rd, input logic rw);
        ex_op = op; ex_alu_result = alu; ex_store_data = sd; ex_rd = rd; ex_regwrite = rw;
    endtask

    task automatic nop();
        drive(OP_ADD, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic load_and_check(input string name, input logic [31:0] addr,
                                  input logic [4:0] rd, input logic [31:0] exp);
        drive(OP_LW, addr, 32'h0, rd, 1'b1); tick();
        nop(); tick();
        check({name, "_data"}, memwb_result, exp);
        check({name, "_rd"}, 32'(memwb_rd), 32'(rd));
        check({name, "_rw"}, 32'(memwb_regwrite), 32'h1);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; memout = 2'd0;
        nop();
        tick(); tick();
        reset = 1'b0;

        // Preload word 4, then run a pipeline that leaves outputs nonzero.
        drive(OP_SW, 32'h10, 32'hCAFEF00D, 5'd9, 1'b0); tick();
        drive(OP_ADD, 32'h77, 32'h0, 5'd3, 1'b1); tick();
        nop(); tick();
        check("pre_memwb_result", memwb_result, 32'h77);
        check("pre_after_rd", 32'(after_rd), 32'd9);

        // Reset clears every output but leaves memory intact.
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_exmem_op", 32'(exmem_op), 32'h0);
        check("rst_memwb_rd", 32'(memwb_rd), 32'h0);
        check("rst_memwb_result", memwb_result, 32'h0);
        check("rst_memwb_regwrite", 32'(memwb_regwrite), 32'h0);
        check("rst_after_rd", 32'(after_rd), 32'h0);
        check("rst_after_result", after_result, 32'h0);
        check("rst_align_err", 32'(align_err), 32'h0);
        load_and_check("retained", 32'h10, 5'd5, 32'hCAFEF00D);

        // Store then immediately load the same word.
        drive(OP_SW, 32'h10, 32'hDEADBEEF, 5'd2, 1'b0); tick();
        load_and_check("sw_lw", 32'h10, 5'd5, 32'hDEADBEEF);

        // Forward from MEM/WB: ADD in MEM/WB while SW (stale rt 0) is in EX/MEM.
        drive(OP_ADD, 32'h1234, 32'h0, 5'd8, 1'b1); tick();
        drive(OP_SW, 32'h20, 32'h0, 5'd8, 1'b0); tick();
        check("fwd1_src", memwb_result, 32'h1234);
        memout = 2'd1; nop(); tick(); memout = 2'd0;
        load_and_check("fwd_memwb", 32'h20, 5'd10, 32'h1234);

        // Forward from WB/after.
        drive(OP_ADD, 32'h55AA, 32'h0, 5'd8, 1'b1); tick();
        nop(); tick();
        drive(OP_SW, 32'h20, 32'h0, 5'd8, 1'b0); tick();
        check("fwd2_src", after_result, 32'h55AA);
        memout = 2'd2; nop(); tick(); memout = 2'd0;
        load_and_check("fwd_after", 32'h20, 5'd10, 32'h55AA);

        // Stall two cycles with SW in EX/MEM.
        drive(OP_ADD, 32'h5, 32'h0, 5'd2, 1'b1); tick();
        drive(OP_SW, 32'h30, 32'h11112222, 5'd4, 1'b0); tick();
        stall = 1'b1; drive(OP_LW, 32'h44, 32'h0, 5'd1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_exmem_op", 32'(exmem_op), 32'(OP_SW));
            check("stall_exmem_rd", 32'(exmem_rd), 32'd4);
            check("stall_memwb_rw", 32'(memwb_regwrite), 32'h0);
        end
        stall = 1'b0; nop(); tick();
        check("unstall_exmem_op", 32'(exmem_op), 32'h0);
        load_and_check("stall_store", 32'h30, 5'd11, 32'h11112222);

        // Stall plus flush turns EX/MEM into a bubble and suppresses the store.
        drive(OP_SW, 32'h40, 32'h0BADF00D, 5'd7, 1'b0); tick();
        drive(OP_SW, 32'h40, 32'h00000099, 5'd7, 1'b0); tick();
        stall = 1'b1; flush = 1'b1; nop(); tick();
        stall = 1'b0; flush = 1'b0;
        check("flush_exmem_op", 32'(exmem_op), 32'h0);
        check("flush_exmem_rd", 32'(exmem_rd), 32'h0);
        load_and_check("flush_nostore", 32'h40, 5'd12, 32'h0BADF00D);

        // Misaligned store: no write, sticky error. Misaligned load returns 0.
        drive(OP_SW, 32'h13, 32'h77777777, 5'd3, 1'b0); tick();
        check("mis_err_before", 32'(align_err), 32'h0);
        nop(); tick();
        check("mis_err_set", 32'(align_err), 32'h1);
        tick(); tick();
        check("mis_err_sticky", 32'(align_err), 32'h1);
        load_and_check("mis_nowrite", 32'h10, 5'd5, 32'hDEADBEEF);
        load_and_check("mis_load", 32'h02, 5'd6, 32'h0);

        // Randomized traffic over eight words with random upper address bits.
        for (int n = 0; n < 2000; n++) begin
            logic [5:0]  op;
            logic [31:0] addr;
            case ($urandom_range(0, 3))
                0:       op = OP_LW;
                1:       op = OP_SW;
                2:       op = OP_ADD;
                default: op = 6'h08;
            endcase
            addr = $urandom;
            addr[9:2] = ($urandom_range(0, 15) == 0) ? addr[9:2] : 8'($urandom_range(0, 7));
            if ($urandom_range(0, 15) != 0) addr[1:0] = 2'b00;
            drive(op, addr, $urandom, 5'($urandom), 1'($urandom));
            memout = 2'($urandom);
            stall  = ($urandom_range(0, 7) == 0);
            flush  = ($urandom_range(0, 9) == 0);
            reset  = ($urandom_range(0, 127) == 0);
            tick();
        end
        reset = 1'b0; stall = 1'b0; flush = 1'b0; nop();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
